// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared constants, clear-FSM encoding and lane helpers
// for the sdp_ram_pipe coefficient store.
package sdp_ram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  function automatic int num_lanes(
    input int data_w,
    input int lane_w
  );
    return data_w / lane_w;
  endfunction

  function automatic bit lanes_ok(
    input int data_w,
    input int lane_w
  );
    return (lane_w > 0) && (data_w % lane_w == 0);
  endfunction

endpackage

// File: rtl/sdp_ram_clear_ctrl.sv
// sdp_ram_clear_ctrl: after reset, sweeps the array writing zeros,
// holding busy high until the last address has been cleared.
module sdp_ram_clear_ctrl
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              busy
);

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        cnt <= cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (&cnt) state_nxt = RUN;
      RUN:   state_nxt = RUN;
    endcase
  end

  always_comb begin
    clear_we   = (state == CLEAR);
    busy       = (state == CLEAR);
    clear_addr = cnt;
  end

endmodule

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple-dual-port RAM, lane write enables, 1/2-cycle read.
// Define SDP_RAM_PIPE_INIT_CLEAR_EN to zero the array after reset.
module sdp_ram_pipe #(
  parameter  int DATA_W      = 56,
  parameter  int ADDR_W      = 9,
  parameter  int LANE_W      = 8,
  parameter  int OUT_REG     = 0,
  parameter  int WRITE_FIRST = 0,
  localparam int NUM_LANES   =
    sdp_ram_pkg::num_lanes(DATA_W, LANE_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [NUM_LANES-1:0] wr_lane_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  import sdp_ram_pkg::*;

  localparam int  DEPTH    = 2 ** ADDR_W;
  localparam bit  WR_FIRST = (WRITE_FIRST != READ_FIRST);

  if (!lanes_ok(DATA_W, LANE_W)) begin : g_bad_lane
    $error("DATA_W must be a multiple of LANE_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;

`ifdef SDP_RAM_PIPE_INIT_CLEAR_EN
  sdp_ram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .busy       (busy)
  );
`else
  assign busy       = 1'b0;
  assign clear_we   = 1'b0;
  assign clear_addr = '0;
`endif

  logic wr_go;
  logic rd_go;
  logic hit;

  assign wr_go = wr_en & ~busy;
  assign rd_go = rd_en & ~busy;
  assign hit   = wr_go && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (wr_lane_en[i])
          mem[wr_addr][i*LANE_W +: LANE_W] <=
            wr_data[i*LANE_W +: LANE_W];
    end
  end

  // Array is sampled at the request edge; write-first merges
  // only the lanes being written on that same edge.
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = mem[rd_addr];
    if (WR_FIRST && hit)
      for (int i = 0; i < NUM_LANES; i++)
        if (wr_lane_en[i])
          rd_word[i*LANE_W +: LANE_W] =
            wr_data[i*LANE_W +: LANE_W];
  end

  logic              s1_vld;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rd_go;
      if (rd_go)
        s1_data <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              s2_vld;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld  <= 1'b0;
        s2_data <= '0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld)
          s2_data <= s1_data;
      end
    end

    assign rd_valid = s2_vld;
    assign rd_data  = s2_data;
  end else begin : g_noreg
    assign rd_valid = s1_vld;
    assign rd_data  = s1_data;
  end

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: two instances (latency 1 read-first,
// latency 2 write-first) driven in parallel from a vector table.
module tb_sdp_ram_pipe;

`ifdef SDP_RAM_PIPE_INIT_CLEAR_EN
  localparam int AW   = 4;
  localparam bit FEAT = 1'b1;
`else
  localparam int AW   = 9;
  localparam bit FEAT = 1'b0;
`endif
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [6:0]    wr_lane_en = '0;
  logic [55:0]   wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [55:0] data0, data1;
  logic        vld0, vld1, busy0, busy1;

  always #5 clk = ~clk;

  sdp_ram_pipe #(
    .DATA_W (56), .ADDR_W (AW), .LANE_W (8),
    .OUT_REG (0), .WRITE_FIRST (0)
  ) dut0 (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_lane_en (wr_lane_en), .wr_data (wr_data),
    .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (data0), .rd_valid (vld0), .busy (busy0)
  );

  sdp_ram_pipe #(
    .DATA_W (56), .ADDR_W (AW), .LANE_W (8),
    .OUT_REG (1), .WRITE_FIRST (1)
  ) dut1 (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_lane_en (wr_lane_en), .wr_data (wr_data),
    .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (data1), .rd_valid (vld1), .busy (busy1)
  );

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] wa;
    logic [6:0]    le;
    logic [55:0]   wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [55:0]   e0;
    logic [55:0]   e1;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(input string nm, input logic we,
    input logic [AW-1:0] wa, input logic [6:0] le,
    input logic [55:0] wd, input logic re, input logic [AW-1:0] ra,
    input logic [55:0] e0, input logic [55:0] e1);
    vec_t v;
    v.name = nm; v.we = we; v.wa = wa; v.le = le; v.wd = wd;
    v.re = re; v.ra = ra; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic vec_t wr(input string nm, input logic [AW-1:0] a,
    input logic [6:0] le, input logic [55:0] d);
    return mk(nm, 1'b1, a, le, d, 1'b0, '0, '0, '0);
  endfunction

  function automatic vec_t rd(input string nm, input logic [AW-1:0] a,
    input logic [55:0] e);
    return mk(nm, 1'b0, '0, '0, '0, 1'b1, a, e, e);
  endfunction

  task automatic idle();
    wr_en = 1'b0; wr_lane_en = '0; wr_data = '0; rd_en = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    wr_en = v.we; wr_addr = v.wa; wr_lane_en = v.le; wr_data = v.wd;
    rd_en = v.re; rd_addr = v.ra;
    @(negedge clk);
    idle();
    chk({v.name, " vld0"}, 64'(vld0), 64'(v.re));
    chk({v.name, " vld1 early"}, 64'(vld1), 64'd0);
    if (v.re) chk({v.name, " data0"}, 64'(data0), 64'(v.e0));
    @(negedge clk);
    chk({v.name, " vld0 late"}, 64'(vld0), 64'd0);
    chk({v.name, " vld1"}, 64'(vld1), 64'(v.re));
    if (v.re) chk({v.name, " data1"}, 64'(data1), 64'(v.e1));
  endtask

  // Reads are requested throughout the busy window; none may emerge.
  task automatic wait_ready(input string nm, input int exp_n);
    int  n = 0;
    bit  leak = 1'b0;
    rd_en = 1'b1; rd_addr = '0;
    while (busy0 && n < 4 * DEPTH + 16) begin
      @(negedge clk);
      n++;
      if (vld0 || vld1) leak = 1'b1;
    end
    rd_en = 1'b0;
    chk({nm, " busy cycles"}, 64'(n), 64'(exp_n));
    chk({nm, " no vld while busy"}, 64'(leak), 64'd0);
    @(negedge clk);
    chk({nm, " no late vld"}, 64'(vld0 | vld1), 64'd0);
  endtask

  logic [55:0] pw [4];

  initial begin
    #2;
    chk("rst vld0", 64'(vld0), 64'd0);
    chk("rst vld1", 64'(vld1), 64'd0);
    chk("rst data0", 64'(data0), 64'd0);
    chk("rst data1", 64'(data1), 64'd0);
    chk("rst busy0", 64'(busy0), 64'(FEAT));
    chk("rst busy1", 64'(busy1), 64'(FEAT));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (FEAT) begin
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1 chk("restart busy", 64'(busy0), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      wait_ready("clear", DEPTH);
      apply(rd("clr rd0", '0, '0));
      apply(rd("clr rdtop", TOP, '0));
    end else begin
      wait_ready("noclr", 0);
    end

    tbl.push_back(wr("w5", 5, 7'h7f, 56'h11223344556677));
    tbl.push_back(rd("r5", 5, 56'h11223344556677));
    tbl.push_back(wr("w5 lane0", 5, 7'h01, 56'hFFFFFFFFFFFFFF));
    tbl.push_back(rd("r5 lane0", 5, 56'h112233445566FF));
    tbl.push_back(wr("w3", 3, 7'h7f, 56'hAAAAAAAAAAAAAA));
    tbl.push_back(mk("coll3", 1'b1, 3, 7'h0f, 56'h55555555555555,
                     1'b1, 3, 56'hAAAAAAAAAAAAAA, 56'hAAAAAA55555555));
    tbl.push_back(rd("r3 after", 3, 56'hAAAAAA55555555));
    tbl.push_back(wr("w7", 7, 7'h7f, 56'h01020304050607));
    tbl.push_back(wr("w7 nolane", 7, 7'h00, 56'hFFFFFFFFFFFFFF));
    tbl.push_back(mk("w7 noen", 1'b0, 7, 7'h7f, 56'hEEEEEEEEEEEEEE,
                     1'b0, 0, '0, '0));
    tbl.push_back(rd("r7", 7, 56'h01020304050607));
    tbl.push_back(wr("w0", 0, 7'h7f, 56'h0A0B0C0D0E0F10));
    tbl.push_back(wr("w1", 1, 7'h7f, 56'h11111111111111));
    tbl.push_back(wr("w2", 2, 7'h7f, 56'h22222222222222));
    tbl.push_back(wr("w2 mid", 2, 7'h24, 56'h33333333333333));
    tbl.push_back(rd("r2 mid", 2, 56'h22332222332222));
    tbl.push_back(wr("wtop", TOP, 7'h7f, 56'hDEADBEEFCAFE01));
    tbl.push_back(rd("rtop", TOP, 56'hDEADBEEFCAFE01));
    tbl.push_back(rd("r0", 0, 56'h0A0B0C0D0E0F10));

    foreach (tbl[i]) apply(tbl[i]);

    // Four back-to-back reads.
    pw[0] = 56'h0A0B0C0D0E0F10;
    pw[1] = 56'h11111111111111;
    pw[2] = 56'h22332222332222;
    pw[3] = 56'hAAAAAA55555555;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pipe vld0 %0d", i), 64'(vld0), 64'd1);
      chk($sformatf("pipe data0 %0d", i), 64'(data0), 64'(pw[i]));
      chk($sformatf("pipe vld1 %0d", i), 64'(vld1), 64'(i != 0));
      if (i != 0)
        chk($sformatf("pipe data1 %0d", i), 64'(data1), 64'(pw[i-1]));
      if (i < 3) rd_addr = AW'(i + 1);
      else rd_en = 1'b0;
    end
    @(negedge clk);
    chk("pipe vld0 end", 64'(vld0), 64'd0);
    chk("pipe vld1 last", 64'(vld1), 64'd1);
    chk("pipe data1 last", 64'(data1), 64'(pw[3]));
    @(negedge clk);
    chk("pipe vld1 end", 64'(vld1), 64'd0);
    chk("pipe hold1", 64'(data1), 64'(pw[3]));
    chk("pipe hold0", 64'(data0), 64'(pw[3]));

    // Write on the edge after a read must not reach that read.
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 5;
    @(negedge clk);
    idle();
    wr_en = 1'b1; wr_addr = 5; wr_lane_en = 7'h7f;
    wr_data = 56'h77777777777777;
    chk("raw data0", 64'(data0), 64'h112233445566FF);
    @(negedge clk);
    idle();
    chk("raw vld1", 64'(vld1), 64'd1);
    chk("raw data1", 64'(data1), 64'h112233445566FF);
    apply(rd("r5 new", 5, 56'h77777777777777));

    // Reset with a read in flight.
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 5;
    @(negedge clk);
    idle();
    #1 rst = 1'b1;
    #1;
    chk("mid rst vld0", 64'(vld0), 64'd0);
    chk("mid rst vld1", 64'(vld1), 64'd0);
    chk("mid rst data0", 64'(data0), 64'd0);
    chk("mid rst data1", 64'(data1), 64'd0);
    @(negedge clk);
    chk("mid rst vld1 hold", 64'(vld1), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst vld1", 64'(vld1), 64'd0);
    chk("post rst data1", 64'(data1), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
